// File: rtl/ad9228_capture_buffer.sv
// Per-channel AD9228 capture buffer: circular sample RAM with pre-trigger window and valid/ready replay.
// Optional internal level trigger enabled by defining AD9228_CAPTURE_LEVEL_TRIG_EN.
module ad9228_capture_buffer #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  dco_div4,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] des_data,
    input  logic                  des_data_valid,
    input  logic                  arm,
    input  logic                  trig,
    input  logic [AW-1:0]         pretrig_len,
`ifdef AD9228_CAPTURE_LEVEL_TRIG_EN
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_level_en,
`endif
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_TRIG,
        S_POST,
        S_READOUT
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_ram_q;

    logic [AW-1:0]         r_pl;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_pre_cnt;
    logic [CW-1:0]         r_post_cnt;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_rd_cnt;

    logic                  r_pend;
    logic                  r_pend_last;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_last;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_last;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_wr_en;
    logic                  w_arm_ok;
    logic                  w_trig_hit;
    logic                  w_rd_issue;
    logic                  w_rd_done;
    logic                  w_accept;
    logic                  w_out_free;
    logic [1:0]            w_occ;
    logic [CW-1:0]         w_post_len;
    logic                  w_int_trig;
    logic                  w_trig_eff;

`ifdef AD9228_CAPTURE_LEVEL_TRIG_EN
    logic [DATA_WIDTH-1:0] r_prev;

    // Previous valid sample; all-ones after arm so the first sample cannot form a crossing.
    always_ff @(posedge dco_div4 or posedge rst) begin
        if (rst) begin
            r_prev <= '1;
        end else if (w_arm_ok) begin
            r_prev <= '1;
        end else if (des_data_valid) begin
            r_prev <= des_data;
        end
    end

    assign w_int_trig = trig_level_en && (r_prev < trig_level) && (trig_level <= des_data);
`else
    assign w_int_trig = 1'b0;
`endif

    assign w_trig_eff = trig | w_int_trig;
    assign w_accept   = r_rd_valid & rd_ready;
    assign w_out_free = ~r_rd_valid | w_accept;
    // Entries held or in flight after this cycle's handshake; at most two data slots exist.
    assign w_occ      = 2'(r_rd_valid) + 2'(r_skid_valid) + 2'(r_pend) - 2'(w_accept);
    assign w_post_len = CW'(DEPTH) - {1'b0, r_pl};

    always_comb begin
        w_next     = r_state;
        w_wr_en    = 1'b0;
        w_arm_ok   = 1'b0;
        w_trig_hit = 1'b0;
        w_rd_issue = 1'b0;
        w_rd_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_arm_ok = 1'b1;
                    w_next   = S_PRE;
                end
            end
            S_PRE: begin
                w_wr_en = des_data_valid;
                if ((r_pl == '0) || (des_data_valid && (r_pre_cnt + AW'(1) == r_pl))) begin
                    w_next = S_WAIT_TRIG;
                end
            end
            S_WAIT_TRIG: begin
                w_wr_en = des_data_valid;
                if (des_data_valid && w_trig_eff) begin
                    w_trig_hit = 1'b1;
                    w_next     = (r_pl == AW'(DEPTH - 1)) ? S_READOUT : S_POST;
                end
            end
            S_POST: begin
                w_wr_en = des_data_valid;
                if (des_data_valid && (r_post_cnt + CW'(1) == w_post_len)) begin
                    w_next = S_READOUT;
                end
            end
            S_READOUT: begin
                w_rd_issue = (r_rd_cnt != CW'(DEPTH)) && (w_occ < 2'd2);
                if (w_accept && r_rd_last) begin
                    w_rd_done = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Sample RAM: synchronous write while capturing, registered read during readout.
    always_ff @(posedge dco_div4) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= des_data;
        end
        if (w_rd_issue) begin
            r_ram_q <= r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge dco_div4 or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pl         <= '0;
            r_wr_ptr     <= '0;
            r_pre_cnt    <= '0;
            r_post_cnt   <= '0;
            r_rd_ptr     <= '0;
            r_rd_cnt     <= '0;
            r_pend       <= 1'b0;
            r_pend_last  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_last    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);

            if (w_arm_ok) begin
                r_pl      <= pretrig_len;
                r_pre_cnt <= '0;
                r_done    <= 1'b0;
            end
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if ((r_state == S_PRE) && des_data_valid) begin
                r_pre_cnt <= r_pre_cnt + AW'(1);
            end
            // Window start is pl samples behind the trigger sample.
            if (w_trig_hit) begin
                r_rd_ptr   <= r_wr_ptr - r_pl;
                r_post_cnt <= CW'(1);
                r_rd_cnt   <= '0;
            end
            if ((r_state == S_POST) && des_data_valid) begin
                r_post_cnt <= r_post_cnt + CW'(1);
            end

            if (w_rd_issue) begin
                r_rd_ptr    <= r_rd_ptr + AW'(1);
                r_rd_cnt    <= r_rd_cnt + CW'(1);
                r_pend      <= 1'b1;
                r_pend_last <= (r_rd_cnt == CW'(DEPTH - 1));
            end else begin
                r_pend <= 1'b0;
            end

            // Output register refills from skid first, then from the RAM; stalls park RAM data in skid.
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_rd_valid   <= 1'b1;
                    r_rd_data    <= r_skid_data;
                    r_rd_last    <= r_skid_last;
                    r_skid_valid <= r_pend;
                    r_skid_data  <= r_ram_q;
                    r_skid_last  <= r_pend_last;
                end else if (r_pend) begin
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= r_ram_q;
                    r_rd_last  <= r_pend_last;
                end else begin
                    r_rd_valid <= 1'b0;
                    r_rd_last  <= 1'b0;
                end
            end else if (r_pend) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= r_ram_q;
                r_skid_last  <= r_pend_last;
            end

            if (w_rd_done) begin
                r_done <= 1'b1;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_last  = r_rd_last;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_ad9228_capture_buffer.sv
// Scoreboard bench for ad9228_capture_buffer (DEPTH=16): ramp captures, sparse valid, stalls, reset abort.
module tb_ad9228_capture_buffer;

    localparam int DW    = 12;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] des_data;
    logic          des_data_valid;
    logic          arm;
    logic          trig;
    logic [AW-1:0] pretrig_len;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          rd_last;
    logic          busy;
    logic          done;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    ad9228_capture_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .dco_div4      (clk),
        .rst           (rst),
        .des_data      (des_data),
        .des_data_valid(des_data_valid),
        .arm           (arm),
        .trig          (trig),
        .pretrig_len   (pretrig_len),
`ifdef AD9228_CAPTURE_LEVEL_TRIG_EN
        .trig_level    (12'h800),
        .trig_level_en (1'b0),
`endif
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_last       (rd_last),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Monitor: every presented sample must match the scoreboard head; pop on handshake.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got data=%0d last=%0b with empty scoreboard", rd_data, rd_last);
            end else begin
                if (rd_data !== exp_q[0].data || rd_last !== exp_q[0].last) begin
                    errors++;
                    $display("FAIL rd_sample: got data=%0d last=%0b expected data=%0d last=%0b",
                             rd_data, rd_last, exp_q[0].data, exp_q[0].last);
                end
                if (rd_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One capture: ramp from start, valid every vper cycles, trig on sample trig_val.
    task automatic capture(input int start, input int pl, input int trig_val, input int vper,
                           input bit trig_pre, input bit rand_rdy, input bit arm_in_ro,
                           input int abort_after);
        int  v;
        int  nvalid;
        int  since_trig;
        bit  trig_seen;
        bit  armed_ro;
        bit  fin;
        bit  valid;
        v = start; nvalid = 0; since_trig = 0; trig_seen = 0; armed_ro = 0; fin = 0;
        if (abort_after == 0) begin
            for (int i = 0; i < DEPTH; i++)
                exp_q.push_back('{data: DW'(trig_val - pl + i), last: (i == DEPTH - 1)});
        end
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 3) begin
                check("busy_after_arm", int'(busy), 1);
                check("done_cleared_by_arm", int'(done), 0);
            end
            if (abort_after > 0 && since_trig >= abort_after) begin
                rst = 1'b1;
                #2;
                check("rst_rd_valid", int'(rd_valid), 0);
                check("rst_rd_data", int'(rd_data), 0);
                check("rst_rd_last", int'(rd_last), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                des_data_valid = 1'b0; trig = 1'b0; arm = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                exp_q.delete();
                fin = 1;
            end else if (cyc > 3 && done) begin
                fin = 1;
            end else begin
                valid = ((cyc % vper) == 0);
                arm = (cyc == 0);
                pretrig_len = AW'(pl);
                trig = 1'b0;
                if (valid) begin
                    if (cyc > 0) nvalid++;
                    if (v == trig_val) begin
                        trig = 1'b1;
                        trig_seen = 1;
                    end
                    if (trig_pre && nvalid >= 1 && nvalid <= pl) trig = 1'b1;
                    if (trig_seen) since_trig++;
                end else begin
                    trig = 1'b1;
                end
                des_data = DW'(v);
                des_data_valid = valid;
                rd_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                if (arm_in_ro && !armed_ro && rd_valid) begin
                    arm = 1'b1;
                    pretrig_len = AW'(3);
                    armed_ro = 1;
                end
                if (valid) v++;
            end
        end
        if (!fin) begin
            errors++;
            checks++;
            $display("FAIL capture_timeout: got done=%0b expected done=1 (start %0d)", done, start);
        end else if (abort_after == 0) begin
            check("done_at_end", int'(done), 1);
            check("busy_at_end", int'(busy), 0);
            check("rd_valid_at_end", int'(rd_valid), 0);
            check("scoreboard_drained", exp_q.size(), 0);
        end
        des_data_valid = 1'b0; trig = 1'b0; arm = 1'b0; rd_ready = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; des_data = '0; des_data_valid = 1'b0; arm = 1'b0; trig = 1'b0;
        pretrig_len = '0; rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_valid", int'(rd_valid), 0);
        check("reset_rd_data", int'(rd_data), 0);
        check("reset_rd_last", int'(rd_last), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Ramp, pl=4, trigger on 20: window 16..31
        capture(0, 4, 20, 1, 0, 0, 0, 0);
        // pl=0, first waiting sample 7 triggers: window 7..22
        capture(5, 0, 7, 1, 0, 0, 0, 0);
        // trig during pre-trigger fill is ignored: window 6..21
        capture(0, 4, 10, 1, 1, 0, 0, 0);
        // valid every 3rd cycle, trig on non-valid cycles ignored: window 115..130
        capture(100, 5, 120, 3, 0, 0, 0, 0);
        // random backpressure plus arm during readout: window 223..238
        capture(200, 7, 230, 1, 0, 1, 1, 0);
        // reset during post-trigger fill
        capture(300, 2, 310, 1, 0, 0, 0, 3);
        // maximum pre-trigger length after reset: window 415..430, trigger is last
        capture(400, 15, 430, 1, 0, 1, 1, 0);
        // sparse valid with stalls
        capture(500, 9, 540, 2, 1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
